// File: rtl/ltica_rx.sv
//------------------------------------------------------------------------------
// ltica_rx : windowed pulse-density decoder for six lamp lines with channel-sequence lock tracking
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ltica_rx #(
  parameter int WIN_LOG2   = 10,
  parameter int LOCK_STEPS = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] jb_in,
  output logic [9:0] level,
  output logic [2:0] chan,
  output logic       valid,
  output logic       idle,
  output logic       locked,
  output logic       seq_err
);

  localparam int CW = WIN_LOG2 + 1;
  localparam int SH = (WIN_LOG2 < 10) ? (10 - WIN_LOG2) : 0;
  localparam int LW = CW + SH;
  localparam int SW = (LOCK_STEPS < 1) ? 1 : $clog2(LOCK_STEPS + 1);

  localparam logic [1:0] S_UNLOCKED = 2'd0;
  localparam logic [1:0] S_ACQUIRE  = 2'd1;
  localparam logic [1:0] S_LOCKED   = 2'd2;

  logic [5:0]          r_sync1, r_sync2;
  logic [WIN_LOG2-1:0] r_win_cnt;
  logic [CW-1:0]       r_cnt   [6];
  logic [CW-1:0]       w_final [6];
  logic                w_win_end;
  logic [CW-1:0]       w_best;
  logic [2:0]          w_best_idx;
  logic                w_all_zero;
  logic [LW-1:0]       w_wide;
  logic [9:0]          w_level;

  logic [1:0]    r_state, w_nxt_state;
  logic [2:0]    r_prev, w_nxt_prev;
  logic [SW-1:0] r_step, w_nxt_step;
  logic          r_seq_err, w_nxt_err;
  logic [2:0]    w_succ;
  logic [SW-1:0] w_step_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_win_cnt <= '0;
    end else begin
      r_sync1   <= jb_in;
      r_sync2   <= r_sync1;
      r_win_cnt <= r_win_cnt + WIN_LOG2'(1);
    end
  end

  assign w_win_end = &r_win_cnt;

  // The final total includes the current sample, so the last cycle of a
  // window is counted while the counters restart from zero for the next one.
  for (genvar g = 0; g < 6; g++) begin : g_final
    assign w_final[g] = r_cnt[g] + CW'(r_sync2[g]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 6; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 6; i++) r_cnt[i] <= w_win_end ? '0 : w_final[i];
    end
  end

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    w_best     = w_final[0];
    w_best_idx = 3'd0;
    for (int i = 1; i < 6; i++) begin
      if (w_final[i] > w_best) begin
        w_best     = w_final[i];
        w_best_idx = 3'(i);
      end
    end
  end

  assign w_all_zero = (w_best == '0);
  assign w_wide     = LW'(w_best) << SH;
  assign w_level    = (w_wide > LW'(1023)) ? 10'd1023 : w_wide[9:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= '0;
      chan  <= '0;
      idle  <= 1'b1;
      valid <= 1'b0;
    end else begin
      valid <= w_win_end;
      if (w_win_end) begin
        idle <= w_all_zero;
        if (!w_all_zero) begin
          level <= w_level;
          chan  <= w_best_idx;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_UNLOCKED;
      r_prev    <= '0;
      r_step    <= '0;
      r_seq_err <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_prev    <= w_nxt_prev;
      r_step    <= w_nxt_step;
      r_seq_err <= w_nxt_err;
    end
  end

  assign w_succ     = (r_prev == 3'd5) ? 3'd0 : r_prev + 3'd1;
  assign w_step_inc = r_step + SW'(1);

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_prev  = r_prev;
    w_nxt_step  = r_step;
    w_nxt_err   = 1'b0;
    if (w_win_end) begin
      if (w_all_zero) begin
        w_nxt_state = S_UNLOCKED;
        w_nxt_step  = '0;
      end else if (r_state == S_UNLOCKED) begin
        w_nxt_state = S_ACQUIRE;
        w_nxt_prev  = w_best_idx;
        w_nxt_step  = '0;
      end else if (w_best_idx == w_succ) begin
        w_nxt_prev = w_best_idx;
        if (r_state == S_ACQUIRE) begin
          w_nxt_step = w_step_inc;
          if (w_step_inc == SW'(LOCK_STEPS)) w_nxt_state = S_LOCKED;
        end
      end else if (w_best_idx != r_prev) begin
        w_nxt_err   = 1'b1;
        w_nxt_step  = '0;
        w_nxt_prev  = w_best_idx;
        w_nxt_state = S_ACQUIRE;
      end
    end
  end

  always_comb begin
    locked  = (r_state == S_LOCKED);
    seq_err = r_seq_err;
  end

endmodule

`default_nettype wire
